// File: rtl/ldn_llr_pack.sv
// Scales, clips and packs signed channel samples into SIMD int8 LLR lanes; 1-cycle latency from completing accept.
// Backpressure: single-entry output register, in_ready_o = ~out_valid_o | out_ready_i (load and drain can overlap).
module ldn_llr_pack #(
    parameter int Q     = 8,
    parameter int SIMD  = 8,
    parameter int IN_W  = 12,
    parameter int SAT   = 63,
    parameter int CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [2:0]                 shift_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [IN_W-1:0]            in_data_i,
    input  logic                       in_last_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [Q*SIMD-1:0]          out_data_o,
    output logic [$clog2(SIMD+1)-1:0]  out_lanes_o,
    output logic                       out_last_o,
    output logic [CNT_W-1:0]           sat_cnt_o,
    input  logic                       sat_clr_i
);

    localparam int LW  = $clog2(SIMD+1);
    localparam int LCW = (SIMD > 1) ? $clog2(SIMD) : 1;

    localparam logic signed [IN_W-1:0] SAT_P  = IN_W'(SAT);
    localparam logic signed [IN_W-1:0] SAT_N  = -SAT_P;
    localparam logic [Q-1:0]           LANE_P = Q'(SAT);
    localparam logic [Q-1:0]           LANE_N = Q'(-SAT);
    localparam logic [CNT_W-1:0]       CNT_MAX = '1;

    logic                     r_out_valid;
    logic [Q*SIMD-1:0]        r_out_data;
    logic [LW-1:0]            r_out_lanes;
    logic                     r_out_last;
    logic [CNT_W-1:0]         r_sat_cnt;
    logic [Q*SIMD-1:0]        r_acc;
    logic [LCW-1:0]           r_lane_cnt;

    logic signed [IN_W-1:0]   w_s;
    logic                     w_hi;
    logic                     w_lo;
    logic                     w_clip;
    logic [Q-1:0]             w_lane;
    logic                     w_accept;
    logic                     w_complete;
    logic [Q*SIMD-1:0]        w_merged;

    assign in_ready_o  = ~r_out_valid | out_ready_i;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_lanes_o = r_out_lanes;
    assign out_last_o  = r_out_last;
    assign sat_cnt_o   = r_sat_cnt;

    // Arithmetic shift floors toward -inf; clip is symmetric so -SAT-1 never reaches a lane.
    assign w_s    = $signed(in_data_i) >>> shift_i;
    assign w_hi   = w_s > SAT_P;
    assign w_lo   = w_s < SAT_N;
    assign w_clip = w_hi | w_lo;
    assign w_lane = w_hi ? LANE_P : (w_lo ? LANE_N : w_s[Q-1:0]);

    assign w_accept   = in_valid_i & in_ready_o;
    assign w_complete = w_accept & ((r_lane_cnt == LCW'(SIMD-1)) | in_last_i);

    always_comb begin
        w_merged = r_acc;
        for (int k = 0; k < SIMD; k++) begin
            if (r_lane_cnt == LCW'(k)) begin
                w_merged[k*Q +: Q] = w_lane;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lanes <= '0;
            r_out_last  <= 1'b0;
            r_sat_cnt   <= '0;
            r_acc       <= '0;
            r_lane_cnt  <= '0;
        end else begin
            if (w_complete) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_merged;
                r_out_lanes <= LW'(r_lane_cnt) + LW'(1);
                r_out_last  <= in_last_i;
                r_acc       <= '0;
                r_lane_cnt  <= '0;
            end else begin
                if (w_accept) begin
                    r_acc      <= w_merged;
                    r_lane_cnt <= r_lane_cnt + LCW'(1);
                end
                if (out_ready_i) begin
                    r_out_valid <= 1'b0;
                end
            end

            if (sat_clr_i) begin
                r_sat_cnt <= '0;
            end else if (w_accept && w_clip && (r_sat_cnt != CNT_MAX)) begin
                r_sat_cnt <= r_sat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ldn_llr_pack.sv
// Scoreboard bench for ldn_llr_pack: driver pushes expected words, monitor pops on each output transfer.
module tb_ldn_llr_pack;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  shift_i = 3'd0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [11:0] in_data_i = '0;
    logic        in_last_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [63:0] out_data_o;
    logic [3:0]  out_lanes_o;
    logic        out_last_o;
    logic [15:0] sat_cnt_o;
    logic        sat_clr_i = 1'b0;

    ldn_llr_pack dut (
        .clk_i(clk_i), .rst_i(rst_i), .shift_i(shift_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_last_i(in_last_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_lanes_o(out_lanes_o), .out_last_o(out_last_o),
        .sat_cnt_o(sat_cnt_o), .sat_clr_i(sat_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  n;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_acc = '0;
    int          m_lane = 0;
    int          exp_sat = 0;
    int          attempts = 0;
    int          rmode = 0;

    // Output transfer monitor: compares every word that leaves the DUT against the scoreboard.
    always begin
        @(negedge clk_i);
        #2;
        if (!rst_i && out_valid_o && out_ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra_word got data=%h lanes=%0d last=%0b, no word expected",
                         out_data_o, out_lanes_o, out_last_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({out_data_o, out_lanes_o, out_last_o} !== {e.d, e.n, e.l}) begin
                    errors++;
                    $display("FAIL sb_word got data=%h lanes=%0d last=%0b exp data=%h lanes=%0d last=%0b",
                             out_data_o, out_lanes_o, out_last_o, e.d, e.n, e.l);
                end
            end
        end
    end

    task automatic set_ready();
        if (rmode == 0)      out_ready_i = 1'b1;
        else if (rmode == 1) out_ready_i = ($urandom_range(0, 3) != 0);
        else                 out_ready_i = 1'b0;
    endtask

    task automatic model_accept(input int x, input bit last, input bit clr);
        int   s;
        int   v;
        bit   c;
        exp_t e;
        s = x >>> shift_i;
        c = 1'b0;
        v = s;
        if (s > 63) begin v = 63; c = 1'b1; end
        else if (s < -63) begin v = -63; c = 1'b1; end
        if (clr) exp_sat = 0;
        else if (c && exp_sat < 65535) exp_sat++;
        m_acc[m_lane*8 +: 8] = v[7:0];
        if (m_lane == 7 || last) begin
            e.d = m_acc;
            e.n = 4'(m_lane + 1);
            e.l = last;
            sb.push_back(e);
            m_acc = '0;
            m_lane = 0;
        end else begin
            m_lane++;
        end
    endtask

    task automatic send(input int x, input bit last, input bit clr);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        while (!done) begin
            @(negedge clk_i);
            in_valid_i = 1'b1;
            in_data_i  = x[11:0];
            in_last_i  = last;
            sat_clr_i  = clr;
            set_ready();
            #1;
            attempts++;
            n++;
            if (in_ready_o) begin
                done = 1'b1;
                model_accept(x, last, clr);
            end else if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout in_ready_o stuck at %0b, required 1 within 2000 cycles", in_ready_o);
                done = 1'b1;
            end
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        sat_clr_i  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        sat_clr_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        sb.delete();
        m_acc = '0;
        m_lane = 0;
        exp_sat = 0;
    endtask

    task automatic check_sat(input string name);
        checks++;
        if (sat_cnt_o !== 16'(exp_sat)) begin
            errors++;
            $display("FAIL %s sat_cnt got %0d exp %0d", name, sat_cnt_o, exp_sat);
        end
    endtask

    task automatic drain();
        int n;
        rmode = 0;
        n = 0;
        while ((sb.size() != 0 || out_valid_o) && n < 500) begin
            @(negedge clk_i);
            in_valid_i = 1'b0;
            set_ready();
            @(posedge clk_i);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain %0d words still expected, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({out_valid_o, in_ready_o, out_data_o, out_lanes_o, out_last_o, sat_cnt_o} !== {1'b0, 1'b1, 64'h0, 4'h0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_state got v=%0b rdy=%0b d=%h n=%0d l=%0b sat=%0d exp v=0 rdy=1 all zero",
                     out_valid_o, in_ready_o, out_data_o, out_lanes_o, out_last_o, sat_cnt_o);
        end
    endtask

    task automatic test_basic();
        rmode = 0;
        shift_i = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            send(i, 1'b0, 1'b0);
            if (i == 7) begin
                checks++;
                if (out_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_valid got %0b exp 0", out_valid_o);
                end
            end
        end
        checks++;
        if ({out_valid_o, out_data_o, out_lanes_o, out_last_o} !== {1'b1, 64'h0807060504030201, 4'd8, 1'b0}) begin
            errors++;
            $display("FAIL basic_word got v=%0b d=%h n=%0d l=%0b exp v=1 d=0807060504030201 n=8 l=0",
                     out_valid_o, out_data_o, out_lanes_o, out_last_o);
        end
        drain();
    endtask

    task automatic test_clip();
        int s[8] = '{100, -100, -64, 63, -63, 0, 64, -1};
        int base;
        base = exp_sat;
        rmode = 0;
        shift_i = 3'd0;
        foreach (s[i]) send(s[i], 1'b0, 1'b0);
        checks++;
        if (out_data_o !== 64'hFF3F00C13FC1C13F) begin
            errors++;
            $display("FAIL clip_word got %h exp ff3f00c13fc1c13f", out_data_o);
        end
        checks++;
        if (sat_cnt_o !== 16'(base + 4)) begin
            errors++;
            $display("FAIL clip_sat got %0d exp %0d", sat_cnt_o, base + 4);
        end
        drain();
    endtask

    task automatic test_scale();
        rmode = 0;
        shift_i = 3'd2;
        send(-5, 1'b0, 1'b0);
        send(255, 1'b0, 1'b0);
        send(256, 1'b1, 1'b0);
        checks++;
        if ({out_data_o, out_lanes_o, out_last_o} !== {64'h00000000003F3FFE, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL scale_word got d=%h n=%0d l=%0b exp d=00000000003f3ffe n=3 l=1",
                     out_data_o, out_lanes_o, out_last_o);
        end
        check_sat("scale");
        shift_i = 3'd0;
        drain();
    endtask

    task automatic test_partial();
        rmode = 0;
        shift_i = 3'd0;
        send(5, 1'b0, 1'b0);
        send(6, 1'b0, 1'b0);
        send(7, 1'b1, 1'b0);
        checks++;
        if ({out_data_o, out_lanes_o, out_last_o} !== {64'h0000000000070605, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL partial_word got d=%h n=%0d l=%0b exp d=0000000000070605 n=3 l=1",
                     out_data_o, out_lanes_o, out_last_o);
        end
        send(9, 1'b1, 1'b0);
        checks++;
        if ({out_data_o, out_lanes_o, out_last_o} !== {64'h0000000000000009, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL single_lane got d=%h n=%0d l=%0b exp d=0000000000000009 n=1 l=1",
                     out_data_o, out_lanes_o, out_last_o);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        rmode = 2;
        shift_i = 3'd0;
        for (int i = 0; i < 8; i++) send(16 + i, 1'b0, 1'b0);
        held = out_data_o;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            set_ready();
            #1;
            checks++;
            if ({in_ready_o, out_valid_o, out_data_o, out_lanes_o} !== {1'b0, 1'b1, held, 4'd8}) begin
                errors++;
                $display("FAIL bp_hold got rdy=%0b v=%0b d=%h n=%0d exp rdy=0 v=1 d=%h n=8",
                         in_ready_o, out_valid_o, out_data_o, out_lanes_o, held);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int a0;
        rmode = 0;
        shift_i = 3'd1;
        a0 = attempts;
        for (int i = 0; i < 32; i++) send($urandom_range(0, 4095) - 2048, 1'b0, 1'b0);
        checks++;
        if (attempts - a0 != 32) begin
            errors++;
            $display("FAIL b2b_cycles got %0d cycles for 32 samples exp 32", attempts - a0);
        end
        drain();
        check_sat("b2b");
    endtask

    task automatic test_random();
        int len;
        bit lst;
        rmode = 1;
        for (int w = 0; w < 100; w++) begin
            shift_i = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 8);
            lst = (len < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++)
                send($urandom_range(0, 4095) - 2048, (i == len - 1) ? lst : 1'b0, 1'b0);
        end
        drain();
        check_sat("random");
    endtask

    task automatic test_mid_reset();
        rmode = 0;
        shift_i = 3'd0;
        for (int i = 0; i < 4; i++) send(40 + i, 1'b0, 1'b0);
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (out_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_valid got %0b exp 0", out_valid_o);
            end
        end
        for (int i = 0; i < 8; i++) send(i + 10, 1'b0, 1'b0);
        checks++;
        if ({out_data_o, out_lanes_o} !== {64'h11100F0E0D0C0B0A, 4'd8}) begin
            errors++;
            $display("FAIL mid_reset_word got d=%h n=%0d exp d=11100f0e0d0c0b0a n=8", out_data_o, out_lanes_o);
        end
        drain();
    endtask

    task automatic test_sat_clr();
        rmode = 0;
        shift_i = 3'd0;
        send(200, 1'b0, 1'b0);
        checks++;
        if (sat_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL sat_pre_clr got %0d exp 1", sat_cnt_o);
        end
        send(-200, 1'b1, 1'b1);
        checks++;
        if (sat_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL sat_clr_wins got %0d exp 0", sat_cnt_o);
        end
        drain();
    endtask

    task automatic test_sat_saturate();
        rmode = 0;
        shift_i = 3'd0;
        for (int i = 0; i < 70000; i++) send((i % 2) ? 2000 : -2000, 1'b0, 1'b0);
        checks++;
        if (sat_cnt_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_saturate got %h exp ffff", sat_cnt_o);
        end
        check_sat("saturate");
        drain();
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        test_reset();
        test_basic();
        test_clip();
        test_scale();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_sat_clr();
        test_sat_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
